// File: rtl/exe_unit_pkg.sv
// Shared types and constants for the sequential execution unit.
package exe_unit_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_MUL = 3'b110,
        OP_DIV = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned ST_ZERO = 0;
    localparam int unsigned ST_NEG  = 1;
    localparam int unsigned ST_OVF  = 2;
    localparam int unsigned ST_ERR  = 3;
    localparam int unsigned ST_W    = 4;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// hi_c/lo_c expose the state after the current iteration so the caller can
// capture the final value on the same edge the last iteration completes.
module seq_muldiv
    import exe_unit_pkg::*;
#(
    parameter int unsigned BITS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  op_e             op,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic            done_c,
    output logic [BITS-1:0] hi_c,
    output logic [BITS-1:0] lo_c
);

    localparam int unsigned CW = (BITS > 1) ? $clog2(BITS) : 1;

    logic            busy_q;
    logic            is_div_q;
    logic [CW-1:0]   count_q;
    logic [BITS-1:0] opnd_q;
    logic [BITS-1:0] hi_q;
    logic [BITS-1:0] lo_q;

    logic [BITS:0]     add_sum;
    logic [2*BITS-1:0] mul_shift;
    logic [BITS:0]     rem_shift;
    logic [BITS:0]     sub_diff;

    // One iteration: MUL keeps {acc, multiplier}, DIV keeps {remainder, quotient}
    always_comb begin
        add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_shift = {add_sum, lo_q[BITS-1:1]};
        rem_shift = {hi_q, lo_q[BITS-1]};
        sub_diff  = rem_shift - {1'b0, opnd_q};
        hi_c      = mul_shift[2*BITS-1:BITS];
        lo_c      = mul_shift[BITS-1:0];
        if (is_div_q) begin
            if (sub_diff[BITS]) begin
                hi_c = rem_shift[BITS-1:0];
                lo_c = {lo_q[BITS-2:0], 1'b0};
            end else begin
                hi_c = sub_diff[BITS-1:0];
                lo_c = {lo_q[BITS-2:0], 1'b1};
            end
        end
        done_c = busy_q && (count_q == CW'(BITS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
            count_q  <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            is_div_q <= (op == OP_DIV);
            count_q  <= '0;
            opnd_q   <= (op == OP_DIV) ? b : a;
            hi_q     <= '0;
            lo_q     <= (op == OP_DIV) ? a : b;
        end else if (busy_q) begin
            hi_q    <= hi_c;
            lo_q    <= lo_c;
            count_q <= count_q + CW'(1);
            if (done_c) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exe_unit_seq.sv
// 8-op execution unit with valid/ready request handshake; single-cycle ALU ops
// plus fixed-latency iterative MUL/DIV through seq_muldiv.
module exe_unit_seq
    import exe_unit_pkg::*;
#(
    parameter int unsigned BITS = 4,
    parameter int unsigned N    = 3
) (
    input  logic            i_clk,
    input  logic            i_rsn,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [BITS-1:0] i_argA,
    input  logic [BITS-1:0] i_argB,
    input  logic [N-1:0]    i_oper,
    output logic            o_valid,
    output logic [BITS-1:0] o_result,
    output logic [ST_W-1:0] o_status
);

    localparam int unsigned MSB = BITS - 1;
    localparam int unsigned SW  = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int unsigned SHW = BITS + (1 << SW);

    state_e state_q, state_d;
    op_e    op_q, op_d;
    op_e    oper;

    logic            ready_d;
    logic            valid_d;
    logic [BITS-1:0] result_d;
    logic [ST_W-1:0] status_d;
    logic            start_c;

    logic [BITS-1:0] alu_res;
    logic            alu_ovf;
    logic            alu_err;
    logic [BITS-1:0] sum;
    logic [BITS-1:0] diff;
    logic [SW-1:0]   shamt;
    logic [SHW-1:0]  shl_full;

    logic            md_done_c;
    logic [BITS-1:0] md_hi_c;
    logic [BITS-1:0] md_lo_c;

    function automatic logic [ST_W-1:0] mk_status(logic [BITS-1:0] r, logic ovf, logic err);
        logic [ST_W-1:0] s;
        s          = '0;
        s[ST_ZERO] = (r == '0);
        s[ST_NEG]  = r[MSB];
        s[ST_OVF]  = ovf;
        s[ST_ERR]  = err;
        return s;
    endfunction

    assign oper = op_e'(3'(i_oper));

    // Single-cycle ops; DIV entry only matters for the divide-by-zero error path
    always_comb begin
        sum      = i_argA + i_argB;
        diff     = i_argA - i_argB;
        shamt    = i_argB[SW-1:0];
        shl_full = SHW'(i_argA) << shamt;
        alu_res  = '0;
        alu_ovf  = 1'b0;
        alu_err  = 1'b0;
        case (oper)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (i_argA[MSB] == i_argB[MSB]) && (sum[MSB] != i_argA[MSB]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (i_argA[MSB] != i_argB[MSB]) && (diff[MSB] != i_argA[MSB]);
            end
            OP_AND: alu_res = i_argA & i_argB;
            OP_OR:  alu_res = i_argA | i_argB;
            OP_XOR: alu_res = i_argA ^ i_argB;
            OP_SHL: begin
                alu_res = shl_full[BITS-1:0];
                alu_ovf = |shl_full[SHW-1:BITS];
            end
            OP_DIV: begin
                alu_res = '1;
                alu_err = 1'b1;
            end
            default: alu_res = '0;
        endcase
    end

    seq_muldiv #(.BITS(BITS)) u_muldiv (
        .clk    (i_clk),
        .rst_n  (i_rsn),
        .start  (start_c),
        .op     (oper),
        .a      (i_argA),
        .b      (i_argB),
        .done_c (md_done_c),
        .hi_c   (md_hi_c),
        .lo_c   (md_lo_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        ready_d  = o_ready;
        valid_d  = 1'b0;
        result_d = o_result;
        status_d = o_status;
        start_c  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (i_valid && o_ready) begin
                    op_d = oper;
                    if (oper == OP_MUL || (oper == OP_DIV && i_argB != '0)) begin
                        start_c = 1'b1;
                        ready_d = 1'b0;
                        state_d = CALC;
                    end else begin
                        valid_d  = 1'b1;
                        result_d = alu_res;
                        status_d = mk_status(alu_res, alu_ovf, alu_err);
                    end
                end
            end
            CALC: begin
                ready_d = 1'b0;
                if (md_done_c) begin
                    state_d  = DONE;
                    valid_d  = 1'b1;
                    result_d = md_lo_c;
                    status_d = mk_status(md_lo_c, (op_q == OP_MUL) && (md_hi_c != '0), 1'b0);
                end
            end
            DONE: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            o_ready  <= 1'b1;
            o_valid  <= 1'b0;
            o_result <= '0;
            o_status <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            o_ready  <= ready_d;
            o_valid  <= valid_d;
            o_result <= result_d;
            o_status <= status_d;
        end
    end

endmodule

// File: tb/tb_exe_unit_seq.sv
// Directed self-checking bench for exe_unit_seq at BITS=4.
module tb_exe_unit_seq;

    localparam int unsigned BITS = 4;
    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
    localparam logic [2:0] XOR_ = 3'b100, SHL = 3'b101, MUL = 3'b110, DIV = 3'b111;

    logic            i_clk;
    logic            i_rsn;
    logic            i_valid;
    logic            o_ready;
    logic [BITS-1:0] i_argA;
    logic [BITS-1:0] i_argB;
    logic [2:0]      i_oper;
    logic            o_valid;
    logic [BITS-1:0] o_result;
    logic [3:0]      o_status;

    int n_checks = 0;
    int n_fail   = 0;

    exe_unit_seq #(.BITS(BITS), .N(3)) dut (
        .i_clk    (i_clk),
        .i_rsn    (i_rsn),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_argA   (i_argA),
        .i_argB   (i_argB),
        .i_oper   (i_oper),
        .o_valid  (o_valid),
        .o_result (o_result),
        .o_status (o_status)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Issue one request (called just after a negedge) and wait for its o_valid.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                          output int lat, output int rdy_low, output logic [3:0] res,
                          output logic [3:0] st, output logic rdy_at_valid);
        for (int k = 0; k < 20 && o_ready !== 1'b1; k++) @(negedge i_clk);
        i_argA = a; i_argB = b; i_oper = op; i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0; i_argA = ~a; i_argB = ~b;
        lat = 1; rdy_low = 0;
        while (o_valid !== 1'b1 && lat < 20) begin
            if (o_ready === 1'b0) rdy_low++;
            @(negedge i_clk);
            lat++;
        end
        res = o_result; st = o_status; rdy_at_valid = o_ready;
    endtask

    task automatic test_reset();
        i_rsn = 1'b1; i_valid = 1'b1; i_oper = ADD; i_argA = 4'b0101; i_argB = 4'b0011;
        #1 i_rsn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            n_checks++;
            if ({o_ready, o_valid, o_result, o_status} !== {1'b1, 1'b0, 4'h0, 4'h0}) begin
                n_fail++;
                $display("FAIL reset_state: got rdy=%b vld=%b res=%b st=%b want 1 0 0000 0000",
                         o_ready, o_valid, o_result, o_status);
            end
        end
        i_valid = 1'b0; i_rsn = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_accept: got vld=%b want 0", o_valid);
        end
    endtask

    task automatic test_back_to_back();
        i_argA = 4'b0111; i_argB = 4'b0001; i_oper = ADD; i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        n_checks++;
        if ({o_ready, o_valid, o_result, o_status} !== {1'b1, 1'b1, 4'b1000, 4'b0110}) begin
            n_fail++;
            $display("FAIL add_ovf: got rdy=%b vld=%b res=%b st=%b want 1 1 1000 0110",
                     o_ready, o_valid, o_result, o_status);
        end
        i_argA = 4'b0001; i_argB = 4'b1000; i_oper = SUB;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        n_checks++;
        if ({o_valid, o_result, o_status} !== {1'b1, 4'b1001, 4'b0110}) begin
            n_fail++;
            $display("FAIL sub_b2b: got vld=%b res=%b st=%b want 1 1001 0110",
                     o_valid, o_result, o_status);
        end
        @(negedge i_clk);
        n_checks++;
        if ({o_valid, o_result, o_status} !== {1'b0, 4'b1001, 4'b0110}) begin
            n_fail++;
            $display("FAIL result_hold: got vld=%b res=%b st=%b want 0 1001 0110",
                     o_valid, o_result, o_status);
        end
    endtask

    task automatic test_mul();
        int lat, rl; logic [3:0] r, s; logic rv;
        run_op(4'b0011, 4'b0101, MUL, lat, rl, r, s, rv);
        n_checks++;
        if (lat != 5 || rl != 4 || rv !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_timing: got lat=%0d rdy_low=%0d rdy=%b want 5 4 0", lat, rl, rv);
        end
        n_checks++;
        if ({r, s} !== {4'b1111, 4'b0010}) begin
            n_fail++;
            $display("FAIL mul_3x5: got res=%b st=%b want 1111 0010", r, s);
        end
        run_op(4'b0100, 4'b0100, MUL, lat, rl, r, s, rv);
        n_checks++;
        if (lat != 5 || {r, s} !== {4'b0000, 4'b0101}) begin
            n_fail++;
            $display("FAIL mul_4x4: got lat=%0d res=%b st=%b want 5 0000 0101", lat, r, s);
        end
    endtask

    task automatic test_div();
        int lat, rl; logic [3:0] r, s; logic rv;
        run_op(4'b1001, 4'b0010, DIV, lat, rl, r, s, rv);
        n_checks++;
        if (lat != 5 || {r, s} !== {4'b0100, 4'b0000}) begin
            n_fail++;
            $display("FAIL div_9by2: got lat=%0d res=%b st=%b want 5 0100 0000", lat, r, s);
        end
        run_op(4'b0111, 4'b0011, DIV, lat, rl, r, s, rv);
        n_checks++;
        if (lat != 5 || {r, s} !== {4'b0010, 4'b0000}) begin
            n_fail++;
            $display("FAIL div_7by3: got lat=%0d res=%b st=%b want 5 0010 0000", lat, r, s);
        end
        run_op(4'b0101, 4'b0000, DIV, lat, rl, r, s, rv);
        n_checks++;
        if (lat != 1 || rv !== 1'b1 || {r, s} !== {4'b1111, 4'b1010}) begin
            n_fail++;
            $display("FAIL div_by_zero: got lat=%0d rdy=%b res=%b st=%b want 1 1 1111 1010",
                     lat, rv, r, s);
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        for (int k = 0; k < 20 && o_ready !== 1'b1; k++) @(negedge i_clk);
        i_argA = 4'b1111; i_argB = 4'b0011; i_oper = DIV; i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rsn = 1'b0;
        #1;
        n_checks++;
        if ({o_ready, o_valid, o_result, o_status} !== {1'b1, 1'b0, 4'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL abort_reset: got rdy=%b vld=%b res=%b st=%b want 1 0 0000 0000",
                     o_ready, o_valid, o_result, o_status);
        end
        @(negedge i_clk);
        i_rsn = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            if (o_valid === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0 || o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_no_valid: got pulses=%0d rdy=%b want 0 1", pulses, o_ready);
        end
    endtask

    task automatic test_logic_shift();
        int lat, rl; logic [3:0] r, s; logic rv;
        run_op(4'b0110, 4'b0010, SHL, lat, rl, r, s, rv);
        n_checks++;
        if (lat != 1 || {r, s} !== {4'b1000, 4'b0110}) begin
            n_fail++;
            $display("FAIL shl_6by2: got lat=%0d res=%b st=%b want 1 1000 0110", lat, r, s);
        end
        run_op(4'b0011, 4'b0001, SHL, lat, rl, r, s, rv);
        n_checks++;
        if ({r, s} !== {4'b0110, 4'b0000}) begin
            n_fail++;
            $display("FAIL shl_3by1: got res=%b st=%b want 0110 0000", r, s);
        end
        run_op(4'b1010, 4'b1010, XOR_, lat, rl, r, s, rv);
        n_checks++;
        if ({r, s} !== {4'b0000, 4'b0001}) begin
            n_fail++;
            $display("FAIL xor_self: got res=%b st=%b want 0000 0001", r, s);
        end
        run_op(4'b1100, 4'b1010, AND_, lat, rl, r, s, rv);
        n_checks++;
        if ({r, s} !== {4'b1000, 4'b0010}) begin
            n_fail++;
            $display("FAIL and: got res=%b st=%b want 1000 0010", r, s);
        end
        run_op(4'b0100, 4'b0001, OR_, lat, rl, r, s, rv);
        n_checks++;
        if ({r, s} !== {4'b0101, 4'b0000}) begin
            n_fail++;
            $display("FAIL or: got res=%b st=%b want 0101 0000", r, s);
        end
    endtask

    task automatic test_mul_zero();
        int lat, rl; logic [3:0] r, s; logic rv;
        run_op(4'b0101, 4'b0000, MUL, lat, rl, r, s, rv);
        n_checks++;
        if (lat != 5 || {r, s} !== {4'b0000, 4'b0001}) begin
            n_fail++;
            $display("FAIL mul_by_zero: got lat=%0d res=%b st=%b want 5 0000 0001", lat, r, s);
        end
    endtask

    task automatic test_ignore_busy();
        int pulses, vlat; logic [3:0] cr, cs;
        for (int k = 0; k < 20 && o_ready !== 1'b1; k++) @(negedge i_clk);
        i_argA = 4'b0010; i_argB = 4'b0011; i_oper = MUL; i_valid = 1'b1;
        @(posedge i_clk);
        pulses = 0; vlat = 0; cr = 4'hx; cs = 4'hx;
        for (int c = 1; c <= 12; c++) begin
            @(negedge i_clk);
            if (o_valid === 1'b1) begin
                pulses++; vlat = c; cr = o_result; cs = o_status;
            end
            if (c < 3) begin
                i_valid = 1'b1; i_argA = 4'b0001; i_argB = 4'b0001; i_oper = ADD;
            end else begin
                i_valid = 1'b0;
            end
        end
        n_checks++;
        if (pulses != 1 || vlat != 5) begin
            n_fail++;
            $display("FAIL busy_ignore_pulses: got pulses=%0d lat=%0d want 1 5", pulses, vlat);
        end
        n_checks++;
        if ({cr, cs} !== {4'b0110, 4'b0000}) begin
            n_fail++;
            $display("FAIL busy_ignore_result: got res=%b st=%b want 0110 0000", cr, cs);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mul();
        test_div();
        test_reset_abort();
        test_logic_shift();
        test_mul_zero();
        test_ignore_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_unit_seq.md
Name: exe_unit_seq

Overview:
Parametrised successor to the combinational/registered 2-bit-opcode execution unit.
- Widens the operation set to 8 ops with a 3-bit opcode.
- Adds a valid/ready input handshake and an o_valid result strobe.
- Adds multi-cycle iterative multiply and divide.
- Sits behind the APB slave register bank: the bank writes operands and opcode, raises i_valid, and captures o_result/o_status on o_valid.

Parameters:
- BITS, 4, operand/result width (>=2).
- N, 3, opcode width (fixed at 3 for this op set; kept as a parameter for the port interface).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rsn  in  1  asynchronous active-low reset.
- i_valid  in  1  request strobe; accepted when i_valid & o_ready.
- o_ready  out  1  unit can accept a request.
- i_argA  in  BITS  operand A.
- i_argB  in  BITS  operand B.
- i_oper  in  N  opcode.
- o_valid  out  1  one-cycle pulse: result/status valid.
- o_result  out  BITS  result, held until the next o_valid.
- o_status  out  4  {err, ovf, neg, zero}, bits [3:0], held with o_result.

Behaviour:
- Reset (i_rsn=0, asynchronous):
  - o_result=0, o_status=0, o_valid=0, o_ready=1.
  - FSM goes to IDLE; the internal accumulator, counter and operand registers are cleared.
- Opcodes:
  - 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR.
  - 101 SHL: A << B[$clog2(BITS)-1:0], logical.
  - 110 MUL: unsigned, low BITS bits of the result.
  - 111 DIV: unsigned quotient A/B; the remainder is discarded.
- Status flags:
  - zero: result == 0.
  - neg: result MSB.
  - ovf for ADD/SUB: signed two's-complement overflow.
  - ovf for SHL: any 1 shifted out.
  - ovf for MUL: upper half of the 2*BITS product is non-zero.
  - ovf is 0 for logic ops and DIV.
  - err: DIV with B == 0. In that case result is all ones, ovf=0, and zero/neg are computed from the all-ones result.
- FSM states: IDLE, CALC, DONE.
  - IDLE: o_ready=1.
    - Accept on i_valid & o_ready: latch A, B and oper.
    - Ops 000-101: compute this edge; next cycle o_valid=1 with the result. Latency 1; state stays IDLE, so back-to-back accepts are allowed every cycle.
    - Op 110/111 with B != 0: go to CALC, count=0, o_ready=0.
    - DIV with B == 0: no CALC; behaves as a 1-cycle op with err=1.
  - CALC: one iteration per cycle, BITS iterations.
    - MUL: shift-add over B's bits.
    - DIV: restoring shift-subtract.
    - On count == BITS-1, go to DONE.
  - DONE: register result/status, o_valid=1 for exactly one cycle, o_ready=0, then IDLE.
    - Multi-cycle latency from the accept edge to o_valid high = BITS+1 cycles.
- i_valid while o_ready=0 is ignored; there is no queueing. Requester holds i_valid until it sees o_ready.
- Operand inputs may change after acceptance without affecting the op in flight.
- MUL by 0 still takes the full BITS+1 cycles (fixed latency).
- Reset mid-CALC aborts the operation: no o_valid, and outputs take their reset values.
- o_result/o_status only change in the cycle o_valid=1.

Decomposition:
- Package exe_unit_pkg:
  - op_e enum (OP_ADD..OP_DIV).
  - state_e enum (IDLE, CALC, DONE).
  - Status bit index constants ST_ZERO=0, ST_NEG=1, ST_OVF=2, ST_ERR=3.
- One sub-module, seq_muldiv:
  - Iterative BITS-cycle multiply/divide datapath: accumulator, shifted operand, counter.
  - Signals: start, op, done, {hi,lo} output.
  - The top module owns the FSM, the 1-cycle ops and flag generation.

Test Plan:
- Reset with i_rsn=0, i_valid=1, oper=000 -> o_ready=1, o_valid=0, o_result=0000, o_status=0000 throughout; no accept.
- BITS=4, ADD 0111+0001 -> 1 cycle after accept o_valid=1, result=1000, status=0110 (ovf, neg). Then SUB 0001-1000 back-to-back -> next cycle result=1001, status=0110.
- MUL 0011*0101 -> o_ready=0 for 4 cycles, o_valid 5 cycles after accept, result=1111, status=0010. MUL 0100*0100 -> result=0000, status=0101 (ovf, zero).
- DIV 1001/0010 -> o_valid after 5 cycles, result=0100, status=0000. DIV 0101/0000 -> o_valid after 1 cycle, result=1111, status=1010 (err, neg).
- SHL 0110<<2 -> result=1000, status=0110 (bit shifted out, neg). XOR 1010^1010 -> result=0000, status=0001.
- Start DIV 1111/0011, drop i_rsn at CALC cycle 2 -> no o_valid, outputs 0, o_ready=1. Pulse i_valid during CALC of a new MUL -> ignored, single o_valid with the MUL result only.
